// File: rtl/seq_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_pkg;

  // Sequencer states: waiting for a word, shifting it out, word exhausted
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Pattern used when the instantiating code does not supply one
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // Width needed to count 0..w inclusive (bit_idx reaches W on the last step)
  function automatic int idx_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Pattern history, fill counter and comparator for one serial bit stream.
// Latency: hit is combinational for the bit presented with en; state updates on that clk edge.
// Backpressure: none; a bit is consumed on every cycle en is high.
module seq_match_core
  import seq_pkg::*;
#(
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(DEFAULT_PATTERN),
  parameter bit              OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  // hist_cnt only needs to reach PLEN, then it saturates
  localparam int HCW = $clog2(PLEN + 1);

  logic [PLEN-1:0] r_hist;
  logic [HCW-1:0]  r_hist_cnt;

  logic [PLEN-1:0] w_hist_nxt;
  logic [HCW-1:0]  w_cnt_nxt;
  logic            w_hit;

  // A one-bit pattern has no older history to keep
  generate
    if (PLEN == 1) begin : g_hist_one
      assign w_hist_nxt = bit_in;
    end else begin : g_hist_multi
      assign w_hist_nxt = {r_hist[PLEN-2:0], bit_in};
    end
  endgenerate

  // Fill count of valid history bits, saturating at PLEN
  assign w_cnt_nxt = (r_hist_cnt == HCW'(PLEN)) ? r_hist_cnt : r_hist_cnt + HCW'(1);

  // A match needs both the right bits and a history fully made of fresh bits
  assign w_hit = en && (w_hist_nxt == PATTERN) && (w_cnt_nxt == HCW'(PLEN));
  assign hit   = w_hit;

  // History and fill count; non-overlap mode restarts the fill after a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist     <= '0;
      r_hist_cnt <= '0;
    end else if (clr) begin
      r_hist     <= '0;
      r_hist_cnt <= '0;
    end else if (en) begin
      r_hist <= w_hist_nxt;
      if (w_hit && !OVERLAP) begin
        r_hist_cnt <= '0;
      end else begin
        r_hist_cnt <= w_cnt_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parallel-load serialiser feeding a parametrised pattern detector with a saturating hit counter.
// Latency: ser_bit/match/bit_idx/busy/done/match_cnt update 1 clk after the accepted step edge.
// Backpressure: none; step outside SHIFT is ignored, and load in the same cycle drops the step.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int              W          = 8,
  parameter int              PLEN       = 4,
  parameter logic [PLEN-1:0] PATTERN    = PLEN'(DEFAULT_PATTERN),
  parameter bit              OVERLAP    = 1'b1,
  parameter bit              MSB_FIRST  = 1'b0,
  parameter bit              SPAN_LOADS = 1'b0,
  parameter int              CW         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             din,
  input  logic                     load,
  input  logic                     step,
  output logic                     ser_bit,
  output logic                     match,
  output logic [CW-1:0]            match_cnt,
  output logic [idx_width(W)-1:0]  bit_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = idx_width(W);

  state_t          r_state;
  logic [W-1:0]    r_shreg;
  logic [BW-1:0]   r_bit_idx;
  logic            r_ser_bit;
  logic            r_match;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_match_cnt;

  logic            w_accept;
  logic            w_bit;
  logic            w_last;
  logic            w_clr;
  logic            w_hit;

  // A step only advances the stream while shifting, and a same-cycle load wins
  assign w_accept = step && (r_state == SHIFT) && !load;

  // Next serial bit sits at the end of the shift register nearest the output
  assign w_bit  = MSB_FIRST ? r_shreg[W-1] : r_shreg[0];
  assign w_last = (r_bit_idx == BW'(W - 1));

  // Without carry-over, every new word starts with an empty history
  assign w_clr  = load && !SPAN_LOADS;

  seq_match_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .en     (w_accept),
    .bit_in (w_bit),
    .hit    (w_hit)
  );

  // Sequencer FSM with its registered status outputs and the word being shifted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_ser_bit <= 1'b0;
      r_match   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (load) begin
      r_state   <= SHIFT;
      r_shreg   <= din;
      r_bit_idx <= '0;
      r_match   <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else if (w_accept) begin
      r_ser_bit <= w_bit;
      r_match   <= w_hit;
      r_shreg   <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
      r_bit_idx <= r_bit_idx + BW'(1);
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  // Match counter sticks at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= '0;
    end else if (w_hit && (r_match_cnt != '1)) begin
      r_match_cnt <= r_match_cnt + CW'(1);
    end
  end

  assign ser_bit   = r_ser_bit;
  assign match     = r_match;
  assign match_cnt = r_match_cnt;
  assign bit_idx   = r_bit_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: seven parameter variants share one stimulus stream.
// Expected values come from constants and a bit-stream reference model.
// Summary line reports errors and total checks.
module tb_seq_detect_param;

  localparam int NI = 7;
  // Variant table: 0 default, 1 no-overlap, 2 CW=2, 3 span loads,
  // 4 MSB-first PLEN=5 span no-overlap, 5 PLEN=1, 6 PLEN=10 > W
  localparam int P_PLEN [NI] = '{4, 4, 4, 4, 5, 1, 10};
  localparam int P_PAT  [NI] = '{'hB, 'hB, 'hB, 'hB, 'h16, 'h1, 'h2D3};
  localparam int P_OVL  [NI] = '{1, 0, 1, 1, 0, 0, 1};
  localparam int P_MSB  [NI] = '{0, 0, 0, 0, 1, 0, 0};
  localparam int P_SPAN [NI] = '{0, 0, 0, 1, 1, 0, 0};
  localparam int P_CW   [NI] = '{8, 8, 2, 8, 8, 8, 8};

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       load;
  logic       step;

  logic       ser  [NI];
  logic       mt   [NI];
  logic       bsy  [NI];
  logic       dn   [NI];
  logic [3:0] bidx [NI];
  logic [7:0] cnt  [NI];
  logic [1:0] cnt2;

  int n_checks;
  int n_err;

  // Reference model state
  bit         m_ser   [NI];
  bit         m_match [NI];
  bit         m_busy  [NI];
  bit         m_done  [NI];
  int         m_idx   [NI];
  int         m_cnt   [NI];
  int         m_fresh [NI];
  longint     m_all   [NI];
  logic [7:0] m_word  [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_detect_param u0 (.clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[0]), .match(mt[0]), .match_cnt(cnt[0]), .bit_idx(bidx[0]), .busy(bsy[0]), .done(dn[0]));
  seq_detect_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[1]), .match(mt[1]), .match_cnt(cnt[1]), .bit_idx(bidx[1]), .busy(bsy[1]), .done(dn[1]));
  seq_detect_param #(.CW(2)) u2 (.clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[2]), .match(mt[2]), .match_cnt(cnt2), .bit_idx(bidx[2]), .busy(bsy[2]), .done(dn[2]));
  assign cnt[2] = {6'b0, cnt2};
  seq_detect_param #(.SPAN_LOADS(1'b1)) u3 (.clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[3]), .match(mt[3]), .match_cnt(cnt[3]), .bit_idx(bidx[3]), .busy(bsy[3]), .done(dn[3]));
  seq_detect_param #(.PLEN(5), .PATTERN(5'b10110), .OVERLAP(1'b0), .MSB_FIRST(1'b1), .SPAN_LOADS(1'b1)) u4 (
    .clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[4]), .match(mt[4]), .match_cnt(cnt[4]), .bit_idx(bidx[4]), .busy(bsy[4]), .done(dn[4]));
  seq_detect_param #(.PLEN(1), .PATTERN(1'b1), .OVERLAP(1'b0)) u5 (.clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[5]), .match(mt[5]), .match_cnt(cnt[5]), .bit_idx(bidx[5]), .busy(bsy[5]), .done(dn[5]));
  seq_detect_param #(.PLEN(10), .PATTERN(10'b10_1101_0011)) u6 (.clk(clk), .rst(rst), .din(din), .load(load), .step(step),
    .ser_bit(ser[6]), .match(mt[6]), .match_cnt(cnt[6]), .bit_idx(bidx[6]), .busy(bsy[6]), .done(dn[6]));

  // Model: the detector sees the stream of accepted bits; a match is the last PLEN
  // bits equalling the pattern, all received since the last history restart point.
  task automatic model_edge(input bit r, input bit l, input bit s, input logic [7:0] d);
    bit     b;
    bit     h;
    longint mask;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_ser[i] = 0; m_match[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        m_idx[i] = 0; m_cnt[i] = 0; m_fresh[i] = 0; m_all[i] = 0;
      end else if (l) begin
        m_word[i] = d; m_idx[i] = 0; m_busy[i] = 1; m_done[i] = 0; m_match[i] = 0;
        if (P_SPAN[i] == 0) m_fresh[i] = 0;
      end else if (s && m_busy[i]) begin
        b = (P_MSB[i] != 0) ? m_word[i][7 - m_idx[i]] : m_word[i][m_idx[i]];
        m_ser[i] = b;
        m_all[i] = (m_all[i] << 1) | longint'(b);
        m_fresh[i]++;
        mask = (64'd1 << P_PLEN[i]) - 1;
        h = (m_fresh[i] >= P_PLEN[i]) && ((m_all[i] & mask) == longint'(P_PAT[i]));
        m_match[i] = h;
        if (h) begin
          if (m_cnt[i] < (1 << P_CW[i]) - 1) m_cnt[i]++;
          if (P_OVL[i] == 0) m_fresh[i] = 0;
        end
        m_idx[i]++;
        if (m_idx[i] == 8) begin
          m_busy[i] = 0; m_done[i] = 1;
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, sample 1 ns later
  task automatic tick(input bit r, input bit l, input bit s, input logic [7:0] d);
    rst = r; load = l; step = s; din = d;
    @(posedge clk);
    model_edge(r, l, s, d);
    #1;
    rst = 1'b0; load = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ser[i], mt[i], bsy[i], dn[i], bidx[i], cnt[i]} !== 16'h0) begin
        n_err++;
        $display("FAIL reset inst%0d got ser=%b match=%b busy=%b done=%b idx=%0d cnt=%0d required all 0",
                 i, ser[i], mt[i], bsy[i], dn[i], bidx[i], cnt[i]);
      end
    end
  endtask

  // Stream 1,0,1,1,0,1,1,0: overlap hits after steps 4 and 7, no-overlap only after 4
  task automatic test_basic_stream();
    logic [7:0] w;
    bit e0, e1;
    w = 8'b0110_1101;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, w);
    n_checks++;
    if (bsy[0] !== 1'b1 || dn[0] !== 1'b0 || bidx[0] !== 4'd0) begin
      n_err++; $display("FAIL load_status got busy=%b done=%b idx=%0d required 1 0 0", bsy[0], dn[0], bidx[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      e0 = (k == 4 || k == 7);
      e1 = (k == 4);
      n_checks++;
      if (mt[0] !== e0 || mt[1] !== e1 || ser[0] !== w[k-1]) begin
        n_err++; $display("FAIL basic_step%0d got ovl=%b novl=%b ser=%b required %b %b %b", k, mt[0], mt[1], ser[0], e0, e1, w[k-1]);
      end
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (mt[0] !== e0 || bidx[0] !== 4'(k)) begin
        n_err++; $display("FAIL basic_hold%0d got match=%b idx=%0d required %b %0d", k, mt[0], bidx[0], e0, k);
      end
    end
    n_checks++;
    if (cnt[0] !== 8'd2 || cnt[1] !== 8'd1 || cnt[5] !== 8'd5 || cnt[6] !== 8'd0) begin
      n_err++; $display("FAIL basic_counts got %0d %0d %0d %0d required 2 1 5 0", cnt[0], cnt[1], cnt[5], cnt[6]);
    end
    n_checks++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      n_err++; $display("FAIL basic_done got done=%b busy=%b required 1 0", dn[0], bsy[0]);
    end
  endtask

  // All-ones word never matches 1011; a step after the last bit changes nothing
  task automatic test_all_ones();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'hFF);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (mt[0] !== 1'b0) begin
        n_err++; $display("FAIL ones_match step%0d got %b required 0", k, mt[0]);
      end
    end
    n_checks++;
    if ({ser[0], mt[0], bsy[0], dn[0], bidx[0], cnt[0]} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 8'd0}) begin
      n_err++; $display("FAIL ones_after9 got ser=%b match=%b busy=%b done=%b idx=%0d cnt=%0d required 1 0 0 1 8 0",
                        ser[0], mt[0], bsy[0], dn[0], bidx[0], cnt[0]);
    end
  endtask

  // Load and step together: load wins, step is dropped, history restarts
  task automatic test_load_step_collision();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'b0110_1101);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 8'h00);
    n_checks++;
    if (bidx[0] !== 4'd0 || bsy[0] !== 1'b1 || dn[0] !== 1'b0 || mt[0] !== 1'b0) begin
      n_err++; $display("FAIL collide_load got idx=%0d busy=%b done=%b match=%b required 0 1 0 0", bidx[0], bsy[0], dn[0], mt[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (mt[0] !== 1'b0 || bidx[0] !== 4'(k) || ser[0] !== 1'b0) begin
        n_err++; $display("FAIL collide_step%0d got match=%b idx=%0d ser=%b required 0 %0d 0", k, mt[0], bidx[0], ser[0], k);
      end
    end
  endtask

  // CW=2 counter saturates at 3; reset mid-shift clears every output
  task automatic test_saturate_and_reset();
    int exp_c [3] = '{2, 3, 3};
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      tick(1'b0, 1'b1, 1'b0, 8'b0110_1101);
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (cnt[2] !== 8'(exp_c[r])) begin
        n_err++; $display("FAIL sat_round%0d got cnt=%0d required %0d", r, cnt[2], exp_c[r]);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 8'b0110_1101);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b1, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ser[i], mt[i], bsy[i], dn[i], bidx[i], cnt[i]} !== 16'h0) begin
        n_err++; $display("FAIL midreset inst%0d got ser=%b match=%b busy=%b done=%b idx=%0d cnt=%0d required all 0",
                          i, ser[i], mt[i], bsy[i], dn[i], bidx[i], cnt[i]);
      end
    end
  endtask

  // Word A ends 1,0 and word B starts 1,1: only the carry-over variant sees 1011
  task automatic test_span_loads();
    bit e3;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h40);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h03);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      e3 = (k == 2);
      n_checks++;
      if (mt[3] !== e3 || mt[0] !== 1'b0) begin
        n_err++; $display("FAIL span_step%0d got span=%b nospan=%b required %b 0", k, mt[3], mt[0], e3);
      end
    end
    n_checks++;
    if (cnt[3] !== 8'd1) begin
      n_err++; $display("FAIL span_count got %0d required 1", cnt[3]);
    end
  endtask

  // Random loads, steps, held steps and resets compared every cycle with the model
  task automatic test_random();
    bit r, l, s;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 1) == 1);
      tick(r, l, s, 8'($urandom));
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if ({ser[i], mt[i], bsy[i], dn[i], bidx[i], cnt[i]} !==
            {m_ser[i], m_match[i], m_busy[i], m_done[i], 4'(m_idx[i]), 8'(m_cnt[i])}) begin
          n_err++;
          $display("FAIL random c%0d inst%0d got ser=%b match=%b busy=%b done=%b idx=%0d cnt=%0d required %b %b %b %b %0d %0d",
                   c, i, ser[i], mt[i], bsy[i], dn[i], bidx[i], cnt[i],
                   m_ser[i], m_match[i], m_busy[i], m_done[i], m_idx[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b0; load = 1'b0; step = 1'b0; din = 8'h00;
    for (int i = 0; i < NI; i++) m_word[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_stream();
    test_all_ones();
    test_load_step_collision();
    test_saturate_and_reset();
    test_span_loads();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
